// File: rtl/lcd_pattern_seq.sv
// ---------------------------------------------------------------------------
// lcd_pattern_seq
//   LCD test-pattern generator. Sits one register stage behind an upstream
//   timing generator and replaces the pixel data with one of five test
//   patterns (bit-walk, colour bars, gray ramp, grid, checkerboard). The
//   pattern auto-advances every FRAMES_PER_PATTERN frames, or on a key
//   request, and only ever changes at a frame start.
//
// Ports
//   rgb_clk            pixel clock, all logic on its rising edge
//   rgb_rst_n          asynchronous active-low reset
//   in_hs/in_vs/in_de  upstream timing (sync level set by SYNC_ACTIVE)
//   in_x/in_y          active pixel coordinates, valid while in_de=1
//   key_next           single-cycle advance request (already debounced)
//   pause              level; freezes auto-advance and checker phase
//   out_hs/out_vs/out_de  timing delayed by one clock
//   out_r/out_g/out_b  RGB565 pixel, zero outside the active area
//   pattern_id         current pattern code
//   frame_tick         one-cycle pulse when out_vs first asserts in a frame
// ---------------------------------------------------------------------------
module lcd_pattern_seq #(
  parameter int   H_ACTIVE           = 480,
  parameter int   V_ACTIVE           = 272,
  parameter int   FRAMES_PER_PATTERN = 120,
  parameter logic SYNC_ACTIVE        = 1'b1
) (
  input  logic       rgb_clk,
  input  logic       rgb_rst_n,
  input  logic       in_hs,
  input  logic       in_vs,
  input  logic       in_de,
  input  logic [9:0] in_x,
  input  logic [9:0] in_y,
  input  logic       key_next,
  input  logic       pause,
  output logic       out_hs,
  output logic       out_vs,
  output logic       out_de,
  output logic [4:0] out_r,
  output logic [5:0] out_g,
  output logic [4:0] out_b,
  output logic [2:0] pattern_id,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    BITWALK  = 3'd0,
    COLORBAR = 3'd1,
    GRAY     = 3'd2,
    GRID     = 3'd3,
    CHECKER  = 3'd4
  } pattern_e;

  localparam int          BAR_W    = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;
  localparam logic [11:0] TERM_CNT = 12'(FRAMES_PER_PATTERN - 1);
  localparam logic [9:0]  X_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [15:0] WHITE    = 16'hFFFF;

  pattern_e    pattern_q, pattern_d;
  logic [11:0] frame_cnt_q, frame_cnt_d;
  logic        phase_q, phase_d;
  logic        pending_q, pending_d;
  logic        vs_prev_q;

  logic        hs_q, vs_q, de_q, tick_q;
  logic [15:0] rgb_q, rgb_d;

  logic        frame_start;

  // Largest column k with x >= H_ACTIVE*k/16.
  function automatic logic [3:0] bitwalk_col(input logic [9:0] x);
    logic [3:0] col;
    int         xi;
    col = 4'd0;
    xi  = int'(x);
    for (int k = 1; k < 16; k++) begin
      if (xi >= (H_ACTIVE * k) / 16) col = 4'(k);
    end
    return col;
  endfunction

  function automatic logic [2:0] bar_index(input logic [9:0] x);
    int b;
    b = int'(x) / BAR_W;
    if (b > 7) b = 7;
    return 3'(b);
  endfunction

  function automatic logic [15:0] bar_color(input logic [2:0] n);
    logic [15:0] c;
    case (n)
      3'd0:    c = {5'd31, 6'd63, 5'd31}; // white
      3'd1:    c = {5'd31, 6'd63, 5'd0 }; // yellow
      3'd2:    c = {5'd0,  6'd63, 5'd31}; // cyan
      3'd3:    c = {5'd0,  6'd63, 5'd0 }; // green
      3'd4:    c = {5'd31, 6'd0,  5'd31}; // magenta
      3'd5:    c = {5'd31, 6'd0,  5'd0 }; // red
      3'd6:    c = {5'd0,  6'd0,  5'd31}; // blue
      default: c = 16'h0000;              // black
    endcase
    return c;
  endfunction

  function automatic pattern_e next_pattern(input pattern_e p);
    pattern_e n;
    case (p)
      BITWALK:  n = COLORBAR;
      COLORBAR: n = GRAY;
      GRAY:     n = GRID;
      GRID:     n = CHECKER;
      default:  n = BITWALK; // CHECKER wraps; unused codes recover here
    endcase
    return n;
  endfunction

  // Rising edge of in_vs into its asserted level. vs_prev_q resets to the
  // asserted level so a reset released mid-sync waits for a fresh edge.
  assign frame_start = (in_vs == SYNC_ACTIVE) && (vs_prev_q != SYNC_ACTIVE);

  // Pattern / frame-counter / phase / pending next state
  always_comb begin
    pattern_d   = pattern_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    pending_d   = pending_q | key_next;
    if (frame_start) begin
      // The pending flag consumed here is the registered one, so a key in
      // this very cycle survives into the next frame.
      pending_d = key_next;
      if (!pause) phase_d = ~phase_q;
      // Key and terminal count share one advance.
      if (pending_q || (!pause && (frame_cnt_q == TERM_CNT))) begin
        pattern_d   = next_pattern(pattern_q);
        frame_cnt_d = 12'd0;
      end else if (!pause) begin
        frame_cnt_d = frame_cnt_q + 12'd1;
      end
    end
  end

  // Pixel generation from the registered pattern and phase
  always_comb begin
    rgb_d = 16'h0000;
    if (in_de) begin
      case (pattern_q)
        BITWALK:  rgb_d = 16'h8000 >> bitwalk_col(in_x);
        COLORBAR: rgb_d = bar_color(bar_index(in_x));
        GRAY:     rgb_d = {in_x[8:4], in_x[8:3], in_x[8:4]};
        GRID: begin
          if ((in_x[4:0] == 5'd0) || (in_y[4:0] == 5'd0) ||
              (in_x == X_LAST) || (in_y == Y_LAST))
            rgb_d = WHITE;
        end
        CHECKER: begin
          if (in_x[5] ^ in_y[5] ^ phase_q) rgb_d = WHITE;
        end
        default:  rgb_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      pattern_q   <= BITWALK;
      frame_cnt_q <= 12'd0;
      phase_q     <= 1'b0;
      pending_q   <= 1'b0;
      vs_prev_q   <= SYNC_ACTIVE;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      tick_q      <= 1'b0;
      rgb_q       <= 16'h0000;
    end else begin
      pattern_q   <= pattern_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      pending_q   <= pending_d;
      vs_prev_q   <= in_vs;
      hs_q        <= in_hs;
      vs_q        <= in_vs;
      de_q        <= in_de;
      tick_q      <= frame_start;
      rgb_q       <= rgb_d;
    end
  end

  assign out_hs     = hs_q;
  assign out_vs     = vs_q;
  assign out_de     = de_q;
  assign out_r      = rgb_q[15:11];
  assign out_g      = rgb_q[10:5];
  assign out_b      = rgb_q[4:0];
  assign pattern_id = pattern_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_lcd_pattern_seq.sv
// ---------------------------------------------------------------------------
// tb_lcd_pattern_seq
//   Directed bench for lcd_pattern_seq with FRAMES_PER_PATTERN=3 and short
//   synthetic frames (a brief vsync pulse plus a handful of pixels).
// ---------------------------------------------------------------------------
module tb_lcd_pattern_seq;

  logic       rgb_clk = 1'b0;
  logic       rgb_rst_n;
  logic       in_hs, in_vs, in_de;
  logic [9:0] in_x, in_y;
  logic       key_next, pause;
  logic       out_hs, out_vs, out_de;
  logic [4:0] out_r;
  logic [5:0] out_g;
  logic [4:0] out_b;
  logic [2:0] pattern_id;
  logic       frame_tick;

  logic [15:0] rgb;
  assign rgb = {out_r, out_g, out_b};

  int n_cmp    = 0;
  int n_mis    = 0;
  int tick_cnt = 0;
  int t0;
  bit exp_phase = 1'b0;

  int pat_tbl [17] = '{0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,0,0};

  lcd_pattern_seq #(
    .H_ACTIVE(480), .V_ACTIVE(272), .FRAMES_PER_PATTERN(3), .SYNC_ACTIVE(1'b1)
  ) dut (
    .rgb_clk(rgb_clk), .rgb_rst_n(rgb_rst_n),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_x(in_x), .in_y(in_y),
    .key_next(key_next), .pause(pause),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .pattern_id(pattern_id), .frame_tick(frame_tick)
  );

  always #5 rgb_clk = ~rgb_clk;

  always @(negedge rgb_clk) if (frame_tick === 1'b1) tick_cnt++;

  task automatic step();
    @(posedge rgb_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [15:0] exp);
    in_de = 1'b1; in_x = 10'(x); in_y = 10'(y);
    step();
    check(tag, {16'd0, rgb}, {16'd0, exp});
  endtask

  // One frame start: vsync asserted for two cycles then released.
  task automatic frame_start();
    in_de = 1'b0; in_vs = 1'b1;
    step();
    key_next = 1'b0;
    check("frame_tick_hi", {31'd0, frame_tick}, 32'd1);
    if (!pause) exp_phase = ~exp_phase;
    step();
    check("frame_tick_lo", {31'd0, frame_tick}, 32'd0);
    in_vs = 1'b0;
    step();
    step();
  endtask

  task automatic key_pulse();
    in_de = 1'b1; in_x = 10'd100; in_y = 10'd10;
    key_next = 1'b1;
    step();
    key_next = 1'b0;
    step();
  endtask

  function automatic logic [15:0] chk_px(input int x, input int y, input bit ph);
    return ((((x >> 5) & 1) ^ ((y >> 5) & 1) ^ int'(ph)) != 0) ? 16'hFFFF : 16'h0000;
  endfunction

  initial begin
    rgb_rst_n = 1'b0;
    in_hs = 1'b1; in_vs = 1'b1; in_de = 1'b1;
    in_x = 10'd5; in_y = 10'd5;
    key_next = 1'b0; pause = 1'b0;

    // Reset state with busy inputs
    step(); step();
    check("rst_out_hs", {31'd0, out_hs}, 32'd0);
    check("rst_out_vs", {31'd0, out_vs}, 32'd0);
    check("rst_out_de", {31'd0, out_de}, 32'd0);
    check("rst_rgb", {16'd0, rgb}, 32'd0);
    check("rst_pattern", {29'd0, pattern_id}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);

    in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0;
    rgb_rst_n = 1'b1;
    step(); step();

    // Bit-walk line: one-hot bit moves every 30 pixels, hs delayed one cycle
    for (int x = 0; x < 480; x++) begin
      in_de = 1'b1; in_x = 10'(x); in_y = 10'd0; in_hs = 1'(x % 2);
      step();
      check("bitwalk_rgb", {16'd0, rgb}, 32'h8000 >> (x / 30));
      check("hs_delay", {31'd0, out_hs}, 32'(x % 2));
    end
    check("de_delay", {31'd0, out_de}, 32'd1);
    in_hs = 1'b0;
    in_de = 1'b0; in_x = 10'd0;
    step();
    check("blank_rgb", {16'd0, rgb}, 32'd0);
    check("blank_de", {31'd0, out_de}, 32'd0);

    // Auto-advance every 3 frames; change visible right after each frame start
    for (int i = 0; i < 16; i++) begin
      check("seq_before", {29'd0, pattern_id}, 32'(pat_tbl[i]));
      frame_start();
      check("seq_after", {29'd0, pattern_id}, 32'(pat_tbl[i+1]));
    end
    check("seq_cnt", {20'd0, dut.frame_cnt_q}, 32'd1);

    // Key advance to COLORBAR, bar colours
    key_pulse();
    check("key_no_midframe", {29'd0, pattern_id}, 32'd0);
    frame_start();
    check("key_pat1", {29'd0, pattern_id}, 32'd1);
    check("key_cnt1", {20'd0, dut.frame_cnt_q}, 32'd0);
    pix("bar_x0",   0,   3, 16'hFFFF);
    pix("bar_x59",  59,  3, 16'hFFFF);
    pix("bar_x60",  60,  3, 16'hFFE0);
    pix("bar_x150", 150, 3, 16'h07FF);
    pix("bar_x419", 419, 3, 16'h001F);
    pix("bar_x479", 479, 3, 16'h0000);

    // Key mid-frame in COLORBAR -> GRAY, counter cleared
    key_pulse();
    check("key_no_midframe2", {29'd0, pattern_id}, 32'd1);
    frame_start();
    check("key_pat2", {29'd0, pattern_id}, 32'd2);
    check("key_cnt2", {20'd0, dut.frame_cnt_q}, 32'd0);
    pix("gray_x344", 344, 0, 16'hAD75);
    pix("gray_x7",   7,   0, 16'h0000);
    pix("gray_x479", 479, 0, 16'hEF7D);

    // Key pending together with terminal count -> single advance
    frame_start();
    frame_start();
    check("term_cnt", {20'd0, dut.frame_cnt_q}, 32'd2);
    key_pulse();
    frame_start();
    check("coincide_pat", {29'd0, pattern_id}, 32'd3);
    check("coincide_cnt", {20'd0, dut.frame_cnt_q}, 32'd0);
    pix("grid_x0",   0,   5,   16'hFFFF);
    pix("grid_x5",   5,   5,   16'h0000);
    pix("grid_xl",   479, 5,   16'hFFFF);
    pix("grid_yl",   5,   271, 16'hFFFF);
    pix("grid_y32",  33,  32,  16'hFFFF);
    pix("grid_x33",  33,  33,  16'h0000);

    // Key in the frame-start cycle is held for the following frame
    key_next = 1'b1;
    frame_start();
    check("samecyc_pat", {29'd0, pattern_id}, 32'd3);
    check("samecyc_cnt", {20'd0, dut.frame_cnt_q}, 32'd1);
    frame_start();
    check("samecyc_next", {29'd0, pattern_id}, 32'd4);
    check("samecyc_cnt0", {20'd0, dut.frame_cnt_q}, 32'd0);

    // Checkerboard and pause
    pix("chk_00",   0,  0,  chk_px(0, 0, exp_phase));
    pix("chk_320",  32, 0,  chk_px(32, 0, exp_phase));
    pix("chk_3232", 32, 32, chk_px(32, 32, exp_phase));
    pause = 1'b1;
    t0 = tick_cnt;
    for (int i = 0; i < 10; i++) frame_start();
    check("pause_ticks", 32'(tick_cnt - t0), 32'd10);
    check("pause_pat", {29'd0, pattern_id}, 32'd4);
    check("pause_cnt", {20'd0, dut.frame_cnt_q}, 32'd0);
    check("pause_phase", {31'd0, dut.phase_q}, {31'd0, exp_phase});
    pix("pause_px", 0, 0, chk_px(0, 0, exp_phase));
    pause = 1'b0;
    frame_start();
    check("unpause_cnt", {20'd0, dut.frame_cnt_q}, 32'd1);
    check("unpause_pat", {29'd0, pattern_id}, 32'd4);
    pix("unpause_px", 0, 0, chk_px(0, 0, exp_phase));

    // Key overrides pause and wraps CHECKER -> BITWALK
    pause = 1'b1;
    key_pulse();
    frame_start();
    check("wrap_pat", {29'd0, pattern_id}, 32'd0);
    check("wrap_cnt", {20'd0, dut.frame_cnt_q}, 32'd0);
    check("wrap_phase", {31'd0, dut.phase_q}, {31'd0, exp_phase});
    pause = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      key_pulse();
      frame_start();
      check("to_grid", {29'd0, pattern_id}, 32'(i));
    end

    // Asynchronous reset mid-line in GRID
    in_vs = 1'b0; in_hs = 1'b1;
    pix("pre_rst_px", 0, 5, 16'hFFFF);
    check("pre_rst_de", {31'd0, out_de}, 32'd1);
    in_vs = 1'b1;
    #2;
    rgb_rst_n = 1'b0;
    #1;
    check("arst_rgb", {16'd0, rgb}, 32'd0);
    check("arst_de", {31'd0, out_de}, 32'd0);
    check("arst_hs", {31'd0, out_hs}, 32'd0);
    check("arst_pat", {29'd0, pattern_id}, 32'd0);
    check("arst_cnt", {20'd0, dut.frame_cnt_q}, 32'd0);
    step();
    rgb_rst_n = 1'b1;
    exp_phase = 1'b0;
    t0 = tick_cnt;
    in_de = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("rel_no_tick", 32'(tick_cnt - t0), 32'd0);
    check("rel_tick_lo", {31'd0, frame_tick}, 32'd0);
    in_vs = 1'b0;
    step();
    in_vs = 1'b1;
    step();
    check("rel_tick_hi", {31'd0, frame_tick}, 32'd1);
    check("rel_tick_cnt", 32'(tick_cnt - t0), 32'd0);
    step();
    check("rel_tick_cnt1", 32'(tick_cnt - t0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
